// File: rtl/data_access_pkg.sv
// data_access_pkg: shared types and helpers for the set-associative data store.
// Holds the eviction FSM encoding, default geometry, byte typedef and parity/index helpers.
// Parity storage itself is only built when DATA_ACCESS_PARITY_EN is defined.
package data_access_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    OUT   = 2'd2
  } evict_state_e;

  typedef logic [7:0] byte_t;

  localparam int DEF_CACHE_SIZE = 16384;
  localparam int DEF_LINE_SIZE  = 64;
  localparam int DEF_NUM_WAYS   = 4;
  localparam int DEF_WORD_SIZE  = 4;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Even parity: the stored bit makes the byte plus parity have an even number of ones.
  function automatic logic byte_par(input byte_t b);
    return ^b;
  endfunction

endpackage

// File: rtl/data_way_ram.sv
// data_way_ram: storage for one way, SETS lines of WORDS*WORD_SIZE bytes, byte-masked writes.
// Latency: write lands at the clock edge; read is combinational on rd_set_i.
// Backpressure: none; the parent arbitrates the single write port.
// Ports: clk_i; we_i/wr_set_i/wr_be_i/wr_line_i write side; rd_set_i -> rd_line_o/rd_bad_o.
// DATA_ACCESS_PARITY_EN: adds one parity bit per byte; rd_bad_o flags bytes whose parity mismatches.
module data_way_ram
  import data_access_pkg::*;
#(
  parameter  int SETS      = 64,
  parameter  int WORDS     = 16,
  parameter  int WORD_SIZE = 4,
  localparam int SET_W     = idx_w(SETS),
  localparam int LBYTES    = WORDS * WORD_SIZE,
  localparam int LINE_W    = 8 * LBYTES
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [SET_W-1:0]  wr_set_i,
  input  logic [LBYTES-1:0] wr_be_i,
  input  logic [LINE_W-1:0] wr_line_i,
  input  logic [SET_W-1:0]  rd_set_i,
  output logic [LINE_W-1:0] rd_line_o,
  output logic [LBYTES-1:0] rd_bad_o
);

  logic [LBYTES-1:0][7:0] mem_q [SETS];
  logic [LBYTES-1:0][7:0] wr_bytes;
  logic [LBYTES-1:0][7:0] rd_bytes;

  assign wr_bytes  = wr_line_i;
  assign rd_bytes  = mem_q[rd_set_i];
  assign rd_line_o = rd_bytes;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < LBYTES; b++) begin
        if (wr_be_i[b]) mem_q[wr_set_i][b] <= wr_bytes[b];
      end
    end
  end

`ifdef DATA_ACCESS_PARITY_EN
  logic [LBYTES-1:0] par_q [SETS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < LBYTES; b++) begin
        if (wr_be_i[b]) par_q[wr_set_i][b] <= byte_par(wr_bytes[b]);
      end
    end
  end

  always_comb begin
    rd_bad_o = '0;
    for (int b = 0; b < LBYTES; b++) begin
      rd_bad_o[b] = byte_par(rd_bytes[b]) != par_q[rd_set_i][b];
    end
  end
`else
  assign rd_bad_o = '0;
`endif

endmodule

// File: rtl/data_access_wb.sv
// data_access_wb: NUM_WAYS-way write-back data store of one cache bank, with dirty-victim eviction.
// Latency: reads return 1 cycle after acceptance; writes and clean fills land at the acceptance edge.
// Backpressure: stall_i or busy_o blocks acceptance; a dirty-victim fill holds busy_o until evict valid/ready.
// Ports: request (read/write/fill, way_sel, set_idx, wsel, pmask, byteen, write_data, fill_data),
//        read response (read_valid, read_data), eviction channel (evict_valid/ready/set/way/data), parity_err.
// DATA_ACCESS_PARITY_EN: per-byte even parity checked on read words and evicted lines; else parity_err_o = 0.
module data_access_wb
  import data_access_pkg::*;
#(
  parameter  int CACHE_ID        = 0,
  parameter  int BANK_ID         = 0,
  parameter  int CACHE_SIZE      = DEF_CACHE_SIZE,
  parameter  int CACHE_LINE_SIZE = DEF_LINE_SIZE,
  parameter  int NUM_BANKS       = 1,
  parameter  int NUM_WAYS        = DEF_NUM_WAYS,
  parameter  int NUM_PORTS       = 1,
  parameter  int WORD_SIZE       = DEF_WORD_SIZE,
  parameter  int WRITEBACK       = 1,
  localparam int SETS   = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS * NUM_WAYS),
  localparam int WORDS  = CACHE_LINE_SIZE / WORD_SIZE,
  localparam int SET_W  = idx_w(SETS),
  localparam int WSEL_W = idx_w(WORDS),
  localparam int WAY_W  = idx_w(NUM_WAYS),
  localparam int WORD_W = 8 * WORD_SIZE,
  localparam int LINE_W = 8 * CACHE_LINE_SIZE
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 stall_i,
  input  logic                                 read_i,
  input  logic                                 write_i,
  input  logic                                 fill_i,
  input  logic [NUM_WAYS-1:0]                  way_sel_i,
  input  logic [SET_W-1:0]                     set_idx_i,
  input  logic [NUM_PORTS-1:0][WSEL_W-1:0]     wsel_i,
  input  logic [NUM_PORTS-1:0]                 pmask_i,
  input  logic [NUM_PORTS-1:0][WORD_SIZE-1:0]  byteen_i,
  input  logic [NUM_PORTS-1:0][WORD_W-1:0]     write_data_i,
  input  logic [LINE_W-1:0]                    fill_data_i,
  output logic                                 busy_o,
  output logic                                 read_valid_o,
  output logic [NUM_PORTS-1:0][WORD_W-1:0]     read_data_o,
  output logic                                 evict_valid_o,
  input  logic                                 evict_ready_i,
  output logic [SET_W-1:0]                     evict_set_o,
  output logic [WAY_W-1:0]                     evict_way_o,
  output logic [LINE_W-1:0]                    evict_data_o,
  output logic                                 parity_err_o
);

  // Trace ids only feed this sanity check; geometry must divide evenly.
  if (CACHE_ID < 0 || BANK_ID < 0 || SETS < 1 || WORDS * WORD_SIZE != CACHE_LINE_SIZE) begin : g_param_chk
    $error("data_access_wb: invalid parameters");
  end

  evict_state_e                    state_q;
  logic [LINE_W-1:0]               fbuf_data_q;
  logic [SET_W-1:0]                fbuf_set_q;
  logic [NUM_WAYS-1:0]             fbuf_way_q;
  logic                            evict_valid_q;
  logic [SET_W-1:0]                evict_set_q;
  logic [WAY_W-1:0]                evict_way_q;
  logic [LINE_W-1:0]               evict_data_q;
  logic                            read_valid_q;
  logic [NUM_PORTS-1:0][WORD_W-1:0] read_data_q, read_data_d;
  logic                            parity_err_q;
  logic [SETS-1:0][NUM_WAYS-1:0]   dirty_q;

  logic accept, rd_acc, wr_acc, fill_acc, sel_dirty, fill_clean, fill_dirty, evict_fire, rd_perr;
  logic [SET_W-1:0]                       rd_set, wr_set;
  logic [NUM_WAYS-1:0]                    wr_way;
  logic                                   we_any;
  logic [WORDS-1:0][WORD_SIZE-1:0]        wr_be_w;
  logic [WORDS-1:0][WORD_SIZE-1:0][7:0]   wr_line_w;
  logic [NUM_WAYS-1:0][LINE_W-1:0]        way_line;
  logic [NUM_WAYS-1:0][CACHE_LINE_SIZE-1:0] way_bad;
  logic [WORDS-1:0][WORD_W-1:0]           sel_words;
  logic [WORDS-1:0][WORD_SIZE-1:0]        sel_bad_w;
  logic [LINE_W-1:0]                      vic_line;
  logic [CACHE_LINE_SIZE-1:0]             vic_bad;
  logic [WAY_W-1:0]                       vic_way_bin;

  assign busy_o     = (state_q != IDLE);
  assign accept     = (read_i | write_i | fill_i) && !stall_i && !busy_o;
  assign rd_acc     = accept && read_i;
  assign wr_acc     = accept && write_i;
  assign fill_acc   = accept && fill_i;
  assign sel_dirty  = (WRITEBACK != 0) && |(dirty_q[set_idx_i] & way_sel_i);
  assign fill_clean = fill_acc && !sel_dirty;
  assign fill_dirty = fill_acc && sel_dirty;
  assign evict_fire = (state_q == OUT) && evict_ready_i;
  // While evicting, the array read port serves the victim line.
  assign rd_set     = busy_o ? fbuf_set_q : set_idx_i;

  // Single write port: eviction completion, clean fill, or merged store, mutually exclusive by busy.
  always_comb begin
    we_any    = 1'b0;
    wr_set    = set_idx_i;
    wr_way    = way_sel_i;
    wr_be_w   = '0;
    wr_line_w = '0;
    if (evict_fire) begin
      we_any    = 1'b1;
      wr_set    = fbuf_set_q;
      wr_way    = fbuf_way_q;
      wr_be_w   = '1;
      wr_line_w = fbuf_data_q;
    end else if (fill_clean) begin
      we_any    = 1'b1;
      wr_be_w   = '1;
      wr_line_w = fill_data_i;
    end else if (wr_acc) begin
      we_any = 1'b1;
      // Ascending port order so the highest port wins a shared byte.
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int b = 0; b < WORD_SIZE; b++) begin
          if (pmask_i[p] && byteen_i[p][b]) begin
            wr_be_w[wsel_i[p]][b]   = 1'b1;
            wr_line_w[wsel_i[p]][b] = write_data_i[p][b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    data_way_ram #(
      .SETS      (SETS),
      .WORDS     (WORDS),
      .WORD_SIZE (WORD_SIZE)
    ) u_ram (
      .clk_i     (clk_i),
      .we_i      (we_any && wr_way[w]),
      .wr_set_i  (wr_set),
      .wr_be_i   (wr_be_w),
      .wr_line_i (wr_line_w),
      .rd_set_i  (rd_set),
      .rd_line_o (way_line[w]),
      .rd_bad_o  (way_bad[w])
    );
  end

  always_comb begin
    sel_words   = '0;
    sel_bad_w   = '0;
    vic_line    = '0;
    vic_bad     = '0;
    vic_way_bin = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_sel_i[w]) begin
        sel_words = sel_words | way_line[w];
        sel_bad_w = sel_bad_w | way_bad[w];
      end
      if (fbuf_way_q[w]) begin
        vic_line    = vic_line | way_line[w];
        vic_bad     = vic_bad | way_bad[w];
        vic_way_bin = WAY_W'(w);
      end
    end
    rd_perr     = 1'b0;
    read_data_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      read_data_d[p] = sel_words[wsel_i[p]];
      rd_perr        = rd_perr | (pmask_i[p] && |sel_bad_w[wsel_i[p]]);
    end
  end

  // Eviction FSM: capture fill, read victim, present it until handshaken, then install fill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      fbuf_data_q   <= '0;
      fbuf_set_q    <= '0;
      fbuf_way_q    <= '0;
      evict_valid_q <= 1'b0;
      evict_set_q   <= '0;
      evict_way_q   <= '0;
      evict_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fill_dirty) begin
            fbuf_data_q <= fill_data_i;
            fbuf_set_q  <= set_idx_i;
            fbuf_way_q  <= way_sel_i;
            state_q     <= EVICT;
          end
        end
        EVICT: begin
          evict_data_q  <= vic_line;
          evict_set_q   <= fbuf_set_q;
          evict_way_q   <= vic_way_bin;
          evict_valid_q <= 1'b1;
          state_q       <= OUT;
        end
        OUT: begin
          if (evict_ready_i) begin
            evict_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
      parity_err_q <= 1'b0;
    end else begin
      // Victim parity is flagged alongside the first cycle it is presented.
      parity_err_q <= (rd_acc && rd_perr) || (state_q == EVICT && |vic_bad);
      if (!stall_i) begin
        read_valid_q <= rd_acc;
        if (rd_acc) read_data_q <= read_data_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dirty_q <= '0;
    end else if (WRITEBACK != 0) begin
      if (wr_acc)          dirty_q[set_idx_i]  <= dirty_q[set_idx_i] | way_sel_i;
      else if (fill_clean) dirty_q[set_idx_i]  <= dirty_q[set_idx_i] & ~way_sel_i;
      else if (evict_fire) dirty_q[fbuf_set_q] <= dirty_q[fbuf_set_q] & ~fbuf_way_q;
    end
  end

  assign read_valid_o  = read_valid_q;
  assign read_data_o   = read_data_q;
  assign evict_valid_o = evict_valid_q;
  assign evict_set_o   = evict_set_q;
  assign evict_way_o   = evict_way_q;
  assign evict_data_o  = evict_data_q;
  assign parity_err_o  = parity_err_q;

  a_req_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({read_i, write_i, fill_i}));
  a_way_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    accept |-> $onehot(way_sel_i));

endmodule
